// File: rtl/sensor_data_deser_pkg.sv
// Shared definitions for the sensor readout deserializer: FSM state encoding
// and default word / frame-counter widths.
package sensor_data_deser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int WORD_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;

endpackage

// File: rtl/deser_out_buf.sv
// One-word pending buffer in front of the readout FIFO write port.
// Drops a completed word and raises a sticky overflow when the buffer cannot take it.
module deser_out_buf
  import sensor_data_deser_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              fifo_full_i,
  input  logic              ovf_clr_i,
  output logic              ready_o,
  output logic              pending_o,
  output logic              fifo_wr_en_o,
  output logic [WORD_W-1:0] fifo_din_o,
  output logic              overflow_o
);

  logic              pending_q;
  logic [WORD_W-1:0] pbuf_q;
  logic              fifo_wr_en_q;
  logic [WORD_W-1:0] fifo_din_q;
  logic              overflow_q;
  logic              drain;

  // A draining buffer frees its slot on the same edge, so it can accept a new word.
  assign drain   = pending_q & ~fifo_full_i;
  assign ready_o = ~pending_q | drain;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pending_q    <= 1'b0;
      pbuf_q       <= '0;
      fifo_wr_en_q <= 1'b0;
      fifo_din_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      fifo_wr_en_q <= drain;
      if (drain) fifo_din_q <= pbuf_q;
      if (load_i && ready_o) begin
        pbuf_q    <= word_i;
        pending_q <= 1'b1;
      end else if (drain) begin
        pending_q <= 1'b0;
      end
      if (load_i && !ready_o) overflow_q <= 1'b1;
      else if (ovf_clr_i)     overflow_q <= 1'b0;
    end
  end

  assign pending_o    = pending_q;
  assign fifo_wr_en_o = fifo_wr_en_q;
  assign fifo_din_o   = fifo_din_q;
  assign overflow_o   = overflow_q;

endmodule

// File: rtl/sensor_data_deser.sv
// Packs the MSB-first serial readout stream into FIFO words per frame,
// counting the bits of each frame and flushing a zero-padded partial word at its end.
module sensor_data_deser
  import sensor_data_deser_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              bit_en,
  input  logic              frame,
  input  logic              data_in,
  input  logic              fifo_full,
  input  logic              ovf_clr,
  output logic              fifo_wr_en,
  output logic [WORD_W-1:0] fifo_din,
  output logic [CNT_W-1:0]  frame_bits,
  output logic              frame_done,
  output logic              overflow,
  output logic              busy
);

  localparam int BC_W = $clog2(WORD_W);

  state_e            state_q;
  logic              frame_q;
  logic              armed_q;
  logic [WORD_W-1:0] sr_q;
  logic [BC_W-1:0]   bitcnt_q;
  logic [BC_W-1:0]   bitcnt_d;
  logic [CNT_W-1:0]  frame_bits_q;
  logic              frame_done_q;

  logic              start;
  logic              word_last;
  logic              load;
  logic              ready;
  logic              pending;
  logic [BC_W:0]     shamt;
  logic [WORD_W-1:0] flush_word;
  logic [WORD_W-1:0] word;

  // armed_q blocks a frame that was already high when reset was released.
  assign start      = frame & ~frame_q & armed_q;
  assign word_last  = bit_en && (bitcnt_q == BC_W'(WORD_W - 1));
  assign bitcnt_d   = !bit_en ? bitcnt_q : (word_last ? '0 : bitcnt_q + 1'b1);
  assign shamt      = (BC_W + 1)'(WORD_W) - {1'b0, bitcnt_q};
  assign flush_word = sr_q << shamt;
  assign load       = ((state_q == SHIFT) && word_last) || ((state_q == FLUSH) && ready);
  assign word       = (state_q == FLUSH) ? flush_word : {sr_q[WORD_W-2:0], data_in};

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q      <= IDLE;
      frame_q      <= 1'b0;
      armed_q      <= 1'b0;
      sr_q         <= '0;
      bitcnt_q     <= '0;
      frame_bits_q <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_q      <= frame;
      armed_q      <= armed_q | ~frame;
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sr_q         <= '0;
            bitcnt_q     <= '0;
            frame_bits_q <= '0;
            state_q      <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_en) begin
            sr_q     <= {sr_q[WORD_W-2:0], data_in};
            bitcnt_q <= bitcnt_d;
            if (frame_bits_q != '1) frame_bits_q <= frame_bits_q + 1'b1;
          end
          if (!frame) state_q <= (bitcnt_d != '0) ? FLUSH : DONE;
        end
        FLUSH: begin
          if (ready) state_q <= DONE;
        end
        DONE: begin
          if (!pending && !fifo_wr_en) begin
            frame_done_q <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  deser_out_buf #(.WORD_W(WORD_W)) u_out_buf (
    .clk_i        (CLK),
    .rst_ni       (Reset),
    .load_i       (load),
    .word_i       (word),
    .fifo_full_i  (fifo_full),
    .ovf_clr_i    (ovf_clr),
    .ready_o      (ready),
    .pending_o    (pending),
    .fifo_wr_en_o (fifo_wr_en),
    .fifo_din_o   (fifo_din),
    .overflow_o   (overflow)
  );

  assign frame_bits = frame_bits_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sensor_data_deser.sv
// Directed self-checking bench for sensor_data_deser with a write/frame_done monitor.
module tb_sensor_data_deser;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        bit_en = 1'b0;
  logic        frame = 1'b0;
  logic        data_in = 1'b0;
  logic        fifo_full = 1'b0;
  logic        ovf_clr = 1'b0;
  logic        fifo_wr_en;
  logic [7:0]  fifo_din;
  logic [15:0] frame_bits;
  logic        frame_done;
  logic        overflow;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int doneCount = 0;
  int wrAtDone = 0;
  logic [7:0] wrQ[$];

  sensor_data_deser dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .bit_en     (bit_en),
    .frame      (frame),
    .data_in    (data_in),
    .fifo_full  (fifo_full),
    .ovf_clr    (ovf_clr),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .frame_bits (frame_bits),
    .frame_done (frame_done),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  // Outputs are sampled on the falling edge, half a cycle after they change.
  always @(negedge CLK) begin
    if (fifo_wr_en) wrQ.push_back(fifo_din);
    if (frame_done) begin
      doneCount = doneCount + 1;
      wrAtDone  = wrQ.size();
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic clearLog();
    wrQ.delete();
    doneCount = 0;
    wrAtDone  = 0;
  endtask

  function automatic logic [31:0] wrAt(input int i);
    if (i < wrQ.size()) return {24'h0, wrQ[i]};
    return 32'hDEAD;
  endfunction

  task automatic sendBit(input logic b);
    bit_en  = 1'b1;
    data_in = b;
    cyc(1);
    bit_en  = 1'b0;
    data_in = 1'b0;
    cyc(1);
  endtask

  task automatic applyStimulus(input logic [7:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) sendBit(v[i]);
  endtask

  task automatic waitDone(input string tag);
    int k;
    k = 0;
    while (doneCount == 0 && k < 100) begin
      cyc(1);
      k++;
    end
    checkOutput(tag, (doneCount != 0) ? 32'd1 : 32'd0, 32'd1);
    cyc(4);
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, "_wr"},   {31'h0, fifo_wr_en}, 32'h0);
    checkOutput({tag, "_din"},  {24'h0, fifo_din},   32'h0);
    checkOutput({tag, "_bits"}, {16'h0, frame_bits}, 32'h0);
    checkOutput({tag, "_done"}, {31'h0, frame_done}, 32'h0);
    checkOutput({tag, "_ovf"},  {31'h0, overflow},   32'h0);
    checkOutput({tag, "_busy"}, {31'h0, busy},       32'h0);
  endtask

  initial begin
    // Reset state
    cyc(3);
    checkIdleZero("rst");
    Reset = 1'b1;
    cyc(3);

    // 16-bit frame: 0xA5, 0x3C
    clearLog();
    frame = 1'b1;
    cyc(2);
    checkOutput("t1_busy", {31'h0, busy}, 32'h1);
    applyStimulus(8'hA5, 8);
    applyStimulus(8'h3C, 8);
    frame = 1'b0;
    waitDone("t1_done_seen");
    checkOutput("t1_nwr",  wrQ.size(), 32'd2);
    checkOutput("t1_w0",   wrAt(0), 32'hA5);
    checkOutput("t1_w1",   wrAt(1), 32'h3C);
    checkOutput("t1_bits", {16'h0, frame_bits}, 32'd16);
    checkOutput("t1_ndone", doneCount, 32'd1);
    checkOutput("t1_ovf",  {31'h0, overflow}, 32'h0);
    checkOutput("t1_idle", {31'h0, busy}, 32'h0);

    // 11-bit frame: 0xFF then 101 -> flushed as 0xA0
    clearLog();
    frame = 1'b1;
    cyc(2);
    applyStimulus(8'hFF, 8);
    applyStimulus(8'h05, 3);
    frame = 1'b0;
    waitDone("t2_done_seen");
    checkOutput("t2_nwr",  wrQ.size(), 32'd2);
    checkOutput("t2_w0",   wrAt(0), 32'hFF);
    checkOutput("t2_w1",   wrAt(1), 32'hA0);
    checkOutput("t2_bits", {16'h0, frame_bits}, 32'd11);
    checkOutput("t2_ndone", doneCount, 32'd1);

    // FIFO full across 24 bits: only the first word survives
    clearLog();
    fifo_full = 1'b1;
    frame = 1'b1;
    cyc(2);
    applyStimulus(8'h11, 8);
    applyStimulus(8'h22, 8);
    applyStimulus(8'h33, 8);
    frame = 1'b0;
    cyc(10);
    checkOutput("t3_ovf_set",  {31'h0, overflow}, 32'h1);
    checkOutput("t3_nwr_full", wrQ.size(), 32'd0);
    checkOutput("t3_nodone",   doneCount, 32'd0);
    checkOutput("t3_busy",     {31'h0, busy}, 32'h1);
    fifo_full = 1'b0;
    waitDone("t3_done_seen");
    checkOutput("t3_nwr",      wrQ.size(), 32'd1);
    checkOutput("t3_w0",       wrAt(0), 32'h11);
    checkOutput("t3_wr_before_done", wrAtDone, 32'd1);
    checkOutput("t3_bits",     {16'h0, frame_bits}, 32'd24);
    checkOutput("t3_ovf_hold", {31'h0, overflow}, 32'h1);
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    cyc(1);
    checkOutput("t3_ovf_clr",  {31'h0, overflow}, 32'h0);

    // 8th bit arrives on the same cycle the frame falls
    clearLog();
    frame = 1'b1;
    cyc(2);
    applyStimulus(8'h61, 7);
    bit_en  = 1'b1;
    data_in = 1'b1;
    frame   = 1'b0;
    cyc(1);
    bit_en  = 1'b0;
    data_in = 1'b0;
    waitDone("t4_done_seen");
    checkOutput("t4_nwr",  wrQ.size(), 32'd1);
    checkOutput("t4_w0",   wrAt(0), 32'hC3);
    checkOutput("t4_bits", {16'h0, frame_bits}, 32'd8);

    // Reset mid-frame with frame held high
    clearLog();
    frame = 1'b1;
    cyc(2);
    applyStimulus(8'h1F, 5);
    Reset = 1'b0;
    cyc(2);
    checkIdleZero("t5_rst");
    Reset = 1'b1;
    cyc(2);
    applyStimulus(8'hFF, 8);
    cyc(3);
    checkOutput("t5_ign_busy", {31'h0, busy}, 32'h0);
    checkOutput("t5_ign_nwr",  wrQ.size(), 32'd0);
    checkOutput("t5_ign_bits", {16'h0, frame_bits}, 32'd0);
    frame = 1'b0;
    cyc(2);
    frame = 1'b1;
    cyc(2);
    applyStimulus(8'h81, 8);
    frame = 1'b0;
    waitDone("t5_done_seen");
    checkOutput("t5_nwr",  wrQ.size(), 32'd1);
    checkOutput("t5_w0",   wrAt(0), 32'h81);
    checkOutput("t5_bits", {16'h0, frame_bits}, 32'd8);

    // Empty frame
    clearLog();
    frame = 1'b1;
    cyc(3);
    frame = 1'b0;
    waitDone("t6_done_seen");
    checkOutput("t6_nwr",   wrQ.size(), 32'd0);
    checkOutput("t6_ndone", doneCount, 32'd1);
    checkOutput("t6_bits",  {16'h0, frame_bits}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
